jtgng_prog_sequencer: RTL

Sits between the MiSTer HPS download port and the SDRAM controller and PROM writers. Converts the `ioctl_*` byte stream into masked SDRAM write requests (`prog_*`) or one-cycle PROM write pulses, depending on the byte address. Buffers one byte while an SDRAM write is outstanding. Holds the game in reset during download and for a fixed post-download interval.

---
 rtl/jtgng_prog_pkg.sv | 22 ++
 rtl/jtgng_prog_sequencer_if.sv | 27 ++
 rtl/jtgng_prog_skid.sv | 52 +++++
 rtl/jtgng_prog_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtgng_prog_pkg.sv
// Shared types and constants for the HPS download sequencer: FSM states,
// SDRAM lane mask encodings and the address-to-lane helper.
package jtgng_prog_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACK = 3'd1,
        GAP      = 3'd2,
        DRAIN    = 3'd3,
        POSTRST  = 3'd4
    } prog_state_t;

    // Active-low byte-lane masks for the 16-bit SDRAM word
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    function automatic logic [1:0] lane_mask(input logic addr_lsb);
        lane_mask = addr_lsb ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtgng_prog_sequencer_if.sv
// SDRAM programming request/acknowledge bus between the download sequencer
// (master) and the SDRAM controller (slave).
interface jtgng_prog_sequencer_if;

    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_rdy;

    modport master (
        output prog_we,
        output prog_addr,
        output prog_data,
        output prog_mask,
        input  prog_rdy
    );

    modport slave (
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        input  prog_mask,
        output prog_rdy
    );

endinterface

// File: rtl/jtgng_prog_skid.sv
// One-entry address/data holding buffer for SDRAM bytes that arrive while a
// write is outstanding; a push into a full buffer is dropped and flagged.
module jtgng_prog_skid (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        push,
    input  logic        pop,
    input  logic [21:0] push_addr,
    input  logic [7:0]  push_data,
    output logic        full,
    output logic [21:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        overflow
);

    logic        full_r;
    logic [21:0] addr_r;
    logic [7:0]  data_r;
    logic        overflow_r;

    // Buffer occupancy, payload capture and sticky loss flag
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            full_r     <= 1'b0;
            addr_r     <= 22'd0;
            data_r     <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push && full_r) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            // A push while full is lost even if the entry is being popped
            if (pop) begin
                full_r <= 1'b0;
            end else if (push && !full_r) begin
                full_r <= 1'b1;
                addr_r <= push_addr;
                data_r <= push_data;
            end else begin
                full_r <= full_r;
            end
        end
    end

    assign full     = full_r;
    assign buf_addr = addr_r;
    assign buf_data = data_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/jtgng_prog_sequencer.sv
// Routes the HPS ioctl byte stream to masked SDRAM write requests or PROM
// write pulses, and holds the game core in reset around a download.
module jtgng_prog_sequencer
    import jtgng_prog_pkg::*;
#(
    parameter logic [21:0] PROM_START = 22'h1F_0000,
    parameter int          PROM_AW    = 10,
    parameter int          RST_CYCLES = 1024
) (
    input  logic               clk_sys,
    input  logic               RESET,
    input  logic               downloading,
    input  logic               ioctl_wr,
    input  logic [21:0]        ioctl_addr,
    input  logic [7:0]         ioctl_data,
    jtgng_prog_sequencer_if.master prog,
    output logic               prom_we,
    output logic [PROM_AW-1:0] prom_addr,
    output logic [7:0]         prom_data,
    output logic               game_rst_req,
    output logic               overflow
);

    localparam int             CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    prog_state_t        state_r;
    logic [CW-1:0]      cnt_r;
    logic               cnt_live_r;
    logic               dl_prev_r;
    logic               prog_we_r;
    logic [21:0]        prog_addr_r;
    logic [7:0]         prog_data_r;
    logic [1:0]         prog_mask_r;
    logic               prom_we_r;
    logic [PROM_AW-1:0] prom_addr_r;
    logic [7:0]         prom_data_r;
    logic               game_rst_r;

    logic               sd_wr_s;
    logic               prom_wr_s;
    logic               fall_s;
    logic               push_s;
    logic               pop_s;
    logic               buf_full_s;
    logic [21:0]        buf_addr_s;
    logic [7:0]         buf_data_s;
    logic [21:0]        iss_addr_s;
    logic [7:0]         iss_data_s;

    // Byte decode, download edge detect and skid buffer control
    always_comb begin
        sd_wr_s   = 1'b0;
        prom_wr_s = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        fall_s    = dl_prev_r & ~downloading;
        if (ioctl_wr && downloading) begin
            if (ioctl_addr >= PROM_START) begin
                prom_wr_s = 1'b1;
            end else begin
                sd_wr_s = 1'b1;
            end
        end else begin
            sd_wr_s   = 1'b0;
            prom_wr_s = 1'b0;
        end
        case (state_r)
            WAIT_ACK: push_s = sd_wr_s;
            GAP: begin
                push_s = sd_wr_s & buf_full_s;
                pop_s  = buf_full_s;
            end
            DRAIN: begin
                push_s = sd_wr_s & (prog_we_r | buf_full_s);
                pop_s  = buf_full_s & ~prog_we_r;
            end
            default: begin
                push_s = 1'b0;
                pop_s  = 1'b0;
            end
        endcase
    end

    // A buffered byte always goes out before a newly arriving one
    always_comb begin
        iss_addr_s = ioctl_addr;
        iss_data_s = ioctl_data;
        if (buf_full_s) begin
            iss_addr_s = buf_addr_s;
            iss_data_s = buf_data_s;
        end else begin
            iss_addr_s = ioctl_addr;
            iss_data_s = ioctl_data;
        end
    end

    jtgng_prog_skid u_skid (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .push      (push_s),
        .pop       (pop_s),
        .push_addr (ioctl_addr),
        .push_data (ioctl_data),
        .full      (buf_full_s),
        .buf_addr  (buf_addr_s),
        .buf_data  (buf_data_s),
        .overflow  (overflow)
    );

    // PROM path: one-cycle pulse, offset relative to PROM_START
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            prom_we_r   <= 1'b0;
            prom_addr_r <= '0;
            prom_data_r <= 8'd0;
        end else begin
            prom_we_r <= prom_wr_s;
            if (prom_wr_s) begin
                prom_addr_r <= PROM_AW'(ioctl_addr - PROM_START);
                prom_data_r <= ioctl_data;
            end else begin
                prom_addr_r <= prom_addr_r;
                prom_data_r <= prom_data_r;
            end
        end
    end

    // SDRAM request FSM and game reset hold
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_r     <= POSTRST;
            cnt_r       <= '0;
            cnt_live_r  <= 1'b0;
            dl_prev_r   <= 1'b0;
            prog_we_r   <= 1'b0;
            prog_addr_r <= 22'd0;
            prog_data_r <= 8'd0;
            prog_mask_r <= MASK_NONE;
            game_rst_r  <= 1'b1;
        end else begin
            dl_prev_r <= downloading;
            case (state_r)
                IDLE: begin
                    game_rst_r <= downloading;
                    if (sd_wr_s) begin
                        prog_we_r   <= 1'b1;
                        prog_addr_r <= {1'b0, iss_addr_s[21:1]};
                        prog_data_r <= iss_data_s;
                        prog_mask_r <= lane_mask(iss_addr_s[0]);
                        state_r     <= WAIT_ACK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_ACK: begin
                    game_rst_r <= downloading;
                    if (prog.prog_rdy) begin
                        prog_we_r   <= 1'b0;
                        prog_mask_r <= MASK_NONE;
                        state_r     <= GAP;
                    end else begin
                        state_r <= WAIT_ACK;
                    end
                end
                GAP: begin
                    game_rst_r <= downloading;
                    if (buf_full_s || sd_wr_s) begin
                        prog_we_r   <= 1'b1;
                        prog_addr_r <= {1'b0, iss_addr_s[21:1]};
                        prog_data_r <= iss_data_s;
                        prog_mask_r <= lane_mask(iss_addr_s[0]);
                        state_r     <= WAIT_ACK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRAIN: begin
                    game_rst_r <= 1'b1;
                    if (prog_we_r) begin
                        if (prog.prog_rdy) begin
                            prog_we_r   <= 1'b0;
                            prog_mask_r <= MASK_NONE;
                        end else begin
                            prog_we_r <= 1'b1;
                        end
                    end else if (buf_full_s || sd_wr_s) begin
                        prog_we_r   <= 1'b1;
                        prog_addr_r <= {1'b0, iss_addr_s[21:1]};
                        prog_data_r <= iss_data_s;
                        prog_mask_r <= lane_mask(iss_addr_s[0]);
                    end else begin
                        cnt_r      <= CNT_LOAD;
                        cnt_live_r <= 1'b1;
                        state_r    <= POSTRST;
                    end
                end
                POSTRST: begin
                    // An unloaded counter (straight out of reset) is armed first
                    if (downloading) begin
                        game_rst_r <= 1'b1;
                        cnt_live_r <= 1'b0;
                        if (sd_wr_s) begin
                            prog_we_r   <= 1'b1;
                            prog_addr_r <= {1'b0, iss_addr_s[21:1]};
                            prog_data_r <= iss_data_s;
                            prog_mask_r <= lane_mask(iss_addr_s[0]);
                            state_r     <= WAIT_ACK;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (!cnt_live_r) begin
                        cnt_r      <= CNT_LOAD;
                        cnt_live_r <= 1'b1;
                        game_rst_r <= 1'b1;
                    end else if (cnt_r == '0) begin
                        cnt_live_r <= 1'b0;
                        game_rst_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r      <= cnt_r - CNT_ONE;
                        game_rst_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= POSTRST;
                    cnt_live_r  <= 1'b0;
                    prog_we_r   <= 1'b0;
                    prog_mask_r <= MASK_NONE;
                    game_rst_r  <= 1'b1;
                end
            endcase
            if (fall_s && (state_r == IDLE || state_r == WAIT_ACK || state_r == GAP)) begin
                state_r    <= DRAIN;
                game_rst_r <= 1'b1;
            end
        end
    end

    assign prog.prog_we   = prog_we_r;
    assign prog.prog_addr = prog_addr_r;
    assign prog.prog_data = prog_data_r;
    assign prog.prog_mask = prog_mask_r;
    assign prom_we        = prom_we_r;
    assign prom_addr      = prom_addr_r;
    assign prom_data      = prom_data_r;
    assign game_rst_req   = game_rst_r;

endmodule
